// File: rtl/div_issue_seq.sv
// div_issue_seq: issue sequencer in front of a fixed-latency array divider.
// Accepts tagged divide requests, registers the operands toward the divider,
// tracks in-flight operations in a LATENCY-deep valid/tag pipe and buffers
// results in a DEPTH-entry FIFO. Credits (FIFO count + in-flight) gate
// in_ready so a divider result always finds a free FIFO slot.
// Optional build macro DIV_ISSUE_SEQ_SAT_EN: results flagged dbz or ovf are
// stored as quotient = all ones, remainder = 0 (flags kept).
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid, once raised, is not expected to drop before the transfer, and
// ready never depends on valid in the same cycle.
module div_issue_seq #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WIDTH-1:0]       in_dividend,
  input  logic [WIDTH-1:0]         in_divisor,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [2*WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_dbz,
  input  logic                     div_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_quotient,
  output logic [WIDTH-1:0]         out_remainder,
  output logic                     out_dbz,
  output logic                     out_ovf,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Operand registers toward the divider
  logic [2*WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0]   r_divisor;

  // In-flight tracking: one valid/tag slot per divider latency cycle
  logic [LATENCY-1:0] r_pipe_vld;
  logic [TAG_W-1:0]   r_pipe_tag [LATENCY];
  logic [CW-1:0]      r_inflight;

  // Result FIFO
  logic [WIDTH-1:0]   r_mem_quot [DEPTH];
  logic [WIDTH-1:0]   r_mem_rem  [DEPTH];
  logic               r_mem_dbz  [DEPTH];
  logic               r_mem_ovf  [DEPTH];
  logic [TAG_W-1:0]   r_mem_tag  [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_issue;
  logic               w_capture;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_occ;
  logic [WIDTH-1:0]   w_cap_quot;
  logic [WIDTH-1:0]   w_cap_rem;

  assign w_occ     = r_count + r_inflight;
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign in_ready  = (w_occ < DEPTH_C);
  assign w_issue   = in_valid & in_ready;
  assign w_capture = r_pipe_vld[LATENCY-1];
  assign w_pop     = out_valid & out_ready;

`ifdef DIV_ISSUE_SEQ_SAT_EN
  // Exceptional results collapse to a fixed pattern so consumers need not
  // interpret whatever the divider left on its outputs.
  assign w_cap_quot = (div_dbz | div_ovf) ? '1 : div_quotient;
  assign w_cap_rem  = (div_dbz | div_ovf) ? '0 : div_remainder;
`else
  assign w_cap_quot = div_quotient;
  assign w_cap_rem  = div_remainder;
`endif

  // Operand registers load on accept and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
    end else if (w_issue) begin
      r_dividend <= in_dividend;
      r_divisor  <= in_divisor;
    end
  end

  // Valid/tag shift pipe mirroring the divider latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_tag[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  // In-flight counter: +1 on issue, -1 when the result is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // FIFO storage and write pointer: capture writes the divider result at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_quot[i] <= '0;
        r_mem_rem[i]  <= '0;
        r_mem_dbz[i]  <= 1'b0;
        r_mem_ovf[i]  <= 1'b0;
        r_mem_tag[i]  <= '0;
      end
    end else if (w_capture) begin
      r_mem_quot[r_wr_ptr] <= w_cap_quot;
      r_mem_rem[r_wr_ptr]  <= w_cap_rem;
      r_mem_dbz[r_wr_ptr]  <= div_dbz;
      r_mem_ovf[r_wr_ptr]  <= div_ovf;
      r_mem_tag[r_wr_ptr]  <= r_pipe_tag[LATENCY-1];
      r_wr_ptr             <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer advances on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // FIFO count: +1 on capture, -1 on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A capture must always find a free slot; the credit check guarantees it.
  assert property (@(posedge clk) disable iff (!rst_n) !(w_capture && w_full));

  assign div_dividend  = r_dividend;
  assign div_divisor   = r_divisor;
  assign out_valid     = !w_empty;
  assign out_quotient  = r_mem_quot[r_rd_ptr];
  assign out_remainder = r_mem_rem[r_rd_ptr];
  assign out_dbz       = r_mem_dbz[r_rd_ptr];
  assign out_ovf       = r_mem_ovf[r_rd_ptr];
  assign out_tag       = r_mem_tag[r_rd_ptr];
  assign occupancy     = w_occ;

endmodule
